// File: rtl/mem_stage_access_unit.sv
// LC-3b memory-stage access engine: drives the data-memory port for loads/stores,
// sequences the two-access LDI/STI, and stalls the pipeline until each access completes.
module mem_stage_access_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       opcode,
    input  logic [15:0]      alu_out,
    input  logic [15:0]      store_data,
    input  logic [2:0]       dest_in,
    input  logic             load_regfile_in,
    input  logic             mem_resp,
    input  logic [15:0]      mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_byte_enable,
    output logic [15:0]      mem_address,
    output logic [15:0]      mem_wdata,
    output logic [15:0]      regfilemux_out,
    output logic [2:0]       dest_out,
    output logic             load_regfile_out,
    output logic             stall_pipeline,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpLdb = 4'b0010;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpStb = 4'b0011;
    localparam logic [3:0] OpSti = 4'b1011;

    typedef enum logic {StIdle, StIndirect} state_e;

    state_e            state_q, state_d;
    logic [15:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              is_mem;
    logic [15:0]       word_addr;

    assign is_mem    = in_valid && (opcode inside {OpLdr, OpLdb, OpLdi, OpStr, OpStb, OpSti});
    assign word_addr = alu_out & 16'hFFFE;

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_byte_enable  = 2'b00;
        mem_address      = 16'h0000;
        mem_wdata        = 16'h0000;
        regfilemux_out   = alu_out;
        dest_out         = dest_in;
        load_regfile_out = load_regfile_in & in_valid;
        stall_pipeline   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_mem) begin
                    stall_pipeline   = 1'b1;
                    load_regfile_out = 1'b0;
                    mem_wdata        = store_data;
                    case (opcode)
                        OpLdr: begin
                            mem_read        = 1'b1;
                            mem_address     = word_addr;
                            mem_byte_enable = 2'b11;
                            if (mem_resp) begin
                                regfilemux_out   = mem_rdata;
                                load_regfile_out = load_regfile_in;
                                stall_pipeline   = 1'b0;
                            end
                        end
                        OpLdb: begin
                            mem_read    = 1'b1;
                            mem_address = alu_out;
                            if (mem_resp) begin
                                regfilemux_out   = alu_out[0] ? {8'h00, mem_rdata[15:8]}
                                                              : {8'h00, mem_rdata[7:0]};
                                load_regfile_out = load_regfile_in;
                                stall_pipeline   = 1'b0;
                            end
                        end
                        OpStr: begin
                            mem_write       = 1'b1;
                            mem_address     = word_addr;
                            mem_byte_enable = 2'b11;
                            if (mem_resp) stall_pipeline = 1'b0;
                        end
                        OpStb: begin
                            mem_write       = 1'b1;
                            mem_address     = alu_out;
                            mem_wdata       = {store_data[7:0], store_data[7:0]};
                            mem_byte_enable = alu_out[0] ? 2'b10 : 2'b01;
                            if (mem_resp) stall_pipeline = 1'b0;
                        end
                        default: begin
                            // LDI/STI: fetch the pointer word first
                            mem_read        = 1'b1;
                            mem_address     = word_addr;
                            mem_byte_enable = 2'b11;
                            if (mem_resp) begin
                                ptr_d   = mem_rdata;
                                state_d = StIndirect;
                            end
                        end
                    endcase
                end
            end
            StIndirect: begin
                stall_pipeline   = 1'b1;
                load_regfile_out = 1'b0;
                mem_address      = ptr_q & 16'hFFFE;
                mem_byte_enable  = 2'b11;
                if (opcode == OpSti) begin
                    mem_write = 1'b1;
                    mem_wdata = store_data;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_resp) begin
                    state_d        = StIdle;
                    stall_pipeline = 1'b0;
                    if (opcode != OpSti) begin
                        regfilemux_out   = mem_rdata;
                        load_regfile_out = load_regfile_in;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        stall_cycles_d = stall_cycles_q;
        if (stall_pipeline && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end

        // Reset drops every request and output immediately, even mid-access
        if (!rst_n) begin
            mem_read         = 1'b0;
            mem_write        = 1'b0;
            mem_byte_enable  = 2'b00;
            mem_address      = 16'h0000;
            mem_wdata        = 16'h0000;
            regfilemux_out   = 16'h0000;
            dest_out         = 3'b000;
            load_regfile_out = 1'b0;
            stall_pipeline   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            ptr_q          <= 16'h0000;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed vector table, hand sequences
// and randomized transactions checked against an access-list reference model.
module tb_mem_stage_access_unit;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] SC_MAX = {CNT_W{1'b1}};

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_BR  = 4'b0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [3:0]       opcode;
    logic [15:0]      alu_out;
    logic [15:0]      store_data;
    logic [2:0]       dest_in;
    logic             load_regfile_in;
    logic             mem_resp;
    logic [15:0]      mem_rdata;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_byte_enable;
    logic [15:0]      mem_address;
    logic [15:0]      mem_wdata;
    logic [15:0]      regfilemux_out;
    logic [2:0]       dest_out;
    logic             load_regfile_out;
    logic             stall_pipeline;
    logic [CNT_W-1:0] stall_cycles;

    int n_total = 0;
    int n_pass  = 0;
    logic [CNT_W-1:0] exp_sc = '0;

    always #5 clk = ~clk;

    mem_stage_access_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .opcode           (opcode),
        .alu_out          (alu_out),
        .store_data       (store_data),
        .dest_in          (dest_in),
        .load_regfile_in  (load_regfile_in),
        .mem_resp         (mem_resp),
        .mem_rdata        (mem_rdata),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .regfilemux_out   (regfilemux_out),
        .dest_out         (dest_out),
        .load_regfile_out (load_regfile_out),
        .stall_pipeline   (stall_pipeline),
        .stall_cycles     (stall_cycles)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [15:0] alu;
        logic [15:0] sd;
        logic        ld;
        logic        resp;
        logic [15:0] rd;
        logic        e_rd;
        logic        e_wr;
        logic [1:0]  e_be;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_rf;
        logic        e_ld;
        logic        e_stall;
        logic [3:0]  m;  // [0] addr, [1] byte enable, [2] wdata, [3] regfilemux
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI};
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                         input logic [15:0] sd, input logic ld, input logic resp,
                         input logic [15:0] rd);
        in_valid        = v;
        opcode          = op;
        alu_out         = alu;
        store_data      = sd;
        load_regfile_in = ld;
        mem_resp        = resp;
        mem_rdata       = rd;
        dest_in         = 3'($urandom_range(0, 7));
    endtask

    task automatic check_cycle(input string nm, input logic e_rd, input logic e_wr,
                               input logic [1:0] e_be, input logic [15:0] e_addr,
                               input logic [15:0] e_wdata, input logic [15:0] e_rf,
                               input logic e_ld, input logic e_stall, input logic [3:0] m);
        chk({nm, ".mem_read"}, 32'(mem_read), 32'(e_rd));
        chk({nm, ".mem_write"}, 32'(mem_write), 32'(e_wr));
        chk({nm, ".load_regfile_out"}, 32'(load_regfile_out), 32'(e_ld));
        chk({nm, ".stall_pipeline"}, 32'(stall_pipeline), 32'(e_stall));
        if (m[0]) chk({nm, ".mem_address"}, 32'(mem_address), 32'(e_addr));
        if (m[1]) chk({nm, ".mem_byte_enable"}, 32'(mem_byte_enable), 32'(e_be));
        if (m[2]) chk({nm, ".mem_wdata"}, 32'(mem_wdata), 32'(e_wdata));
        if (m[3]) chk({nm, ".regfilemux_out"}, 32'(regfilemux_out), 32'(e_rf));
        if (rst_n) chk({nm, ".dest_out"}, 32'(dest_out), 32'(dest_in));
        if (e_stall && exp_sc != SC_MAX) exp_sc = exp_sc + 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Non-memory op or bubble: single cycle, value passes straight through
    task automatic idle_op(input string nm, input logic v, input logic [3:0] op,
                           input logic [15:0] alu, input logic ld, input logic resp);
        drive(v, op, alu, 16'($urandom), ld, resp, 16'($urandom));
        #2;
        check_cycle(nm, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0, alu, ld & v, 1'b0, 4'h8);
        next_cycle();
    endtask

    // Reference model: expand the instruction into its list of memory accesses,
    // then walk each access through its latency with stall held until the last response.
    task automatic mem_txn(input string nm, input logic [3:0] op, input logic [15:0] alu,
                           input logic [15:0] sd, input logic ld, input int l1, input int l2,
                           input logic [15:0] r1, input logic [15:0] r2);
        logic [15:0] a_addr [2];
        logic        a_wr   [2];
        logic [1:0]  a_be   [2];
        logic [15:0] a_wd   [2];
        logic [3:0]  a_m    [2];
        int          lat    [2];
        int          n;
        logic        is_ld;
        logic [15:0] res;
        logic [15:0] word;
        logic [15:0] ptr;
        word = {alu[15:1], 1'b0};
        ptr  = {r1[15:1], 1'b0};
        lat[0] = l1;
        lat[1] = l2;
        n = 1;
        is_ld = 1'b0;
        res = 16'h0;
        a_wd[0] = 16'h0;
        a_wd[1] = 16'h0;
        case (op)
            OP_LDR: begin
                a_addr[0] = word; a_wr[0] = 1'b0; a_be[0] = 2'b11; a_m[0] = 4'h3;
                is_ld = 1'b1; res = r1;
            end
            OP_LDB: begin
                a_addr[0] = alu; a_wr[0] = 1'b0; a_be[0] = 2'b00; a_m[0] = 4'h1;
                is_ld = 1'b1; res = alu[0] ? {8'h00, r1[15:8]} : {8'h00, r1[7:0]};
            end
            OP_STR: begin
                a_addr[0] = word; a_wr[0] = 1'b1; a_be[0] = 2'b11; a_wd[0] = sd; a_m[0] = 4'h7;
            end
            OP_STB: begin
                a_addr[0] = alu; a_wr[0] = 1'b1; a_be[0] = alu[0] ? 2'b10 : 2'b01;
                a_wd[0] = {sd[7:0], sd[7:0]}; a_m[0] = 4'h7;
            end
            OP_LDI: begin
                n = 2;
                a_addr[0] = word; a_wr[0] = 1'b0; a_be[0] = 2'b00; a_m[0] = 4'h1;
                a_addr[1] = ptr;  a_wr[1] = 1'b0; a_be[1] = 2'b00; a_m[1] = 4'h1;
                is_ld = 1'b1; res = r2;
            end
            default: begin
                n = 2;
                a_addr[0] = word; a_wr[0] = 1'b0; a_be[0] = 2'b00; a_m[0] = 4'h1;
                a_addr[1] = ptr;  a_wr[1] = 1'b1; a_be[1] = 2'b11; a_wd[1] = sd; a_m[1] = 4'h7;
            end
        endcase
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c <= lat[i]; c++) begin
                logic resp;
                logic last;
                resp = (c == lat[i]);
                last = resp && (i == n - 1);
                drive(1'b1, op, alu, sd, ld, resp,
                      resp ? ((i == 0) ? r1 : r2) : 16'($urandom));
                #2;
                check_cycle($sformatf("%s.acc%0d.c%0d", nm, i, c), !a_wr[i], a_wr[i], a_be[i],
                            a_addr[i], a_wd[i], res, last && is_ld ? ld : 1'b0, !last,
                            a_m[i] | ((last && is_ld) ? 4'h8 : 4'h0));
                next_cycle();
            end
        end
        chk({nm, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_sc));
    endtask

    vec_t tbl [12];

    initial begin
        logic [3:0] ops [11];
        tbl[0]  = '{1'b1, OP_ADD, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0, 4'h8};
        tbl[1]  = '{1'b0, OP_LDR, 16'h0061, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0061, 1'b0, 1'b0, 4'h8};
        tbl[2]  = '{1'b1, OP_LDR, 16'h0061, 16'h0000, 1'b1, 1'b1, 16'hBEEF,
                    1'b1, 1'b0, 2'b11, 16'h0060, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 4'hB};
        tbl[3]  = '{1'b1, OP_LDB, 16'h0101, 16'h0000, 1'b1, 1'b1, 16'hA55A,
                    1'b1, 1'b0, 2'b00, 16'h0101, 16'h0000, 16'h00A5, 1'b1, 1'b0, 4'h9};
        tbl[4]  = '{1'b1, OP_LDB, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'hA55A,
                    1'b1, 1'b0, 2'b00, 16'h0100, 16'h0000, 16'h005A, 1'b1, 1'b0, 4'h9};
        tbl[5]  = '{1'b1, OP_STB, 16'h0100, 16'h12CD, 1'b1, 1'b1, 16'h0000,
                    1'b0, 1'b1, 2'b01, 16'h0100, 16'hCDCD, 16'h0000, 1'b0, 1'b0, 4'h7};
        tbl[6]  = '{1'b1, OP_STB, 16'h0101, 16'h12CD, 1'b1, 1'b0, 16'h0000,
                    1'b0, 1'b1, 2'b10, 16'h0101, 16'hCDCD, 16'h0000, 1'b0, 1'b1, 4'h7};
        tbl[7]  = '{1'b1, OP_STR, 16'h0123, 16'h9876, 1'b1, 1'b1, 16'h0000,
                    1'b0, 1'b1, 2'b11, 16'h0122, 16'h9876, 16'h0000, 1'b0, 1'b0, 4'h7};
        tbl[8]  = '{1'b1, OP_LDR, 16'h0ABC, 16'h0000, 1'b1, 1'b0, 16'hDEAD,
                    1'b1, 1'b0, 2'b11, 16'h0ABC, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h3};
        tbl[9]  = '{1'b1, OP_LDI, 16'h0201, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    1'b1, 1'b0, 2'b00, 16'h0200, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h1};
        tbl[10] = '{1'b1, OP_NOT, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000,
                    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'h8};
        tbl[11] = '{1'b1, OP_STI, 16'h0401, 16'h0000, 1'b1, 1'b0, 16'h0000,
                    1'b1, 1'b0, 2'b00, 16'h0400, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h1};

        // Reset: a live LDR on the inputs must not leak through
        rst_n = 1'b0;
        drive(1'b1, OP_LDR, 16'h0061, 16'h5555, 1'b1, 1'b1, 16'hBEEF);
        #3;
        check_cycle("reset", 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'hF);
        chk("reset.stall_cycles", 32'(stall_cycles), 32'(0));
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        exp_sc = '0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].alu, tbl[i].sd, tbl[i].ld, tbl[i].resp, tbl[i].rd);
            #2;
            check_cycle($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_be,
                        tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_rf, tbl[i].e_ld,
                        tbl[i].e_stall, tbl[i].m);
            next_cycle();
        end
        chk("vec.stall_cycles", 32'(stall_cycles), 32'(exp_sc));

        mem_txn("ldr_lat3", OP_LDR, 16'h0061, 16'h0000, 1'b1, 3, 0, 16'hBEEF, 16'h0000);
        mem_txn("ldb_hi", OP_LDB, 16'h0101, 16'h0000, 1'b1, 1, 0, 16'hA55A, 16'h0000);
        mem_txn("stb_lo", OP_STB, 16'h0100, 16'h12CD, 1'b1, 2, 0, 16'h0000, 16'h0000);
        mem_txn("ldi", OP_LDI, 16'h0200, 16'h0000, 1'b1, 1, 2, 16'h3001, 16'h7777);
        mem_txn("sti", OP_STI, 16'h0400, 16'hCAFE, 1'b0, 0, 1, 16'h5000, 16'h0000);
        mem_txn("ldi_b2b", OP_LDI, 16'h0ABD, 16'h0000, 1'b1, 0, 0, 16'h1235, 16'h4321);
        idle_op("bubble_ldr", 1'b0, OP_LDR, 16'h0061, 1'b1, 1'b0);

        // Reset pulsed while in the indirect phase of an LDI
        drive(1'b1, OP_LDI, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h3001);
        #2;
        check_cycle("rst_ldi.acc0", 1'b1, 1'b0, 2'b00, 16'h0200, 16'h0, 16'h0, 1'b0, 1'b1, 4'h1);
        next_cycle();
        drive(1'b1, OP_LDI, 16'h0200, 16'h0000, 1'b1, 1'b0, 16'h0000);
        #2;
        check_cycle("rst_ldi.acc1", 1'b1, 1'b0, 2'b00, 16'h3000, 16'h0, 16'h0, 1'b0, 1'b1, 4'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_cycle("rst_mid", 1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h1);
        chk("rst_mid.stall_cycles", 32'(stall_cycles), 32'(0));
        exp_sc = '0;
        next_cycle();
        rst_n = 1'b1;
        idle_op("stray_resp_add", 1'b1, OP_ADD, 16'h4242, 1'b1, 1'b1);
        mem_txn("post_rst_str", OP_STR, 16'h0011, 16'h4444, 1'b1, 1, 0, 16'h0000, 16'h0000);

        ops = '{OP_ADD, OP_AND, OP_NOT, OP_LEA, OP_BR, OP_LDR, OP_LDB, OP_LDI,
                OP_STR, OP_STB, OP_STI};
        for (int t = 0; t < 80; t++) begin
            logic [3:0] op;
            logic       v;
            op = ops[$urandom_range(0, 10)];
            v  = ($urandom_range(0, 4) != 0);
            if (v && is_mem_op(op)) begin
                mem_txn($sformatf("rnd%0d", t), op, 16'($urandom), 16'($urandom),
                        1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                        16'($urandom), 16'($urandom));
            end else begin
                idle_op($sformatf("rnd%0d", t), v, op, 16'($urandom), 1'($urandom),
                        1'($urandom));
            end
        end
        chk("final.stall_cycles", 32'(stall_cycles), 32'(exp_sc));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Memory-stage access engine of the pipelined LC-3b core.
- Consumes the EX/MEM latched instruction and drives the data-memory port.
- Produces the writeback value, destination and write enable that feed the MEM/WB register.
- Owns stall_pipeline: holds all pipeline registers until every data access (including the two-access LDI/STI) completes.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- opcode  in  4  lc3b_opcode of the EX/MEM instruction.
- alu_out  in  16  effective address for memory ops; result for non-memory ops.
- store_data  in  16  SR value for STR/STB/STI.
- dest_in  in  3  destination register.
- load_regfile_in  in  1  decode-time regfile write enable.
- mem_resp  in  1  data-memory completion, one-cycle pulse.
- mem_rdata  in  16  read data, valid with mem_resp.
- mem_read  out  1  read request, held until mem_resp.
- mem_write  out  1  write request, held until mem_resp.
- mem_byte_enable  out  2  byte lanes for a write.
- mem_address  out  16  access address.
- mem_wdata  out  16  write data.
- regfilemux_out  out  16  writeback value to MEM/WB.
- dest_out  out  3  destination to MEM/WB.
- load_regfile_out  out  1  writeback enable to MEM/WB.
- stall_pipeline  out  1  freeze all pipeline registers.
- stall_cycles  out  CNT_W  count of cycles with stall_pipeline = 1.

Behaviour:
- FSM states: IDLE, INDIRECT. Reset → IDLE. Pointer register ptr (16 bits) resets to 0. stall_cycles resets to 0.
- While rst_n = 0: mem_read, mem_write, stall_pipeline, load_regfile_out forced 0; all other outputs 0.
- Memory ops: LDR 0110, LDB 0010, LDI 1010, STR 0111, STB 0011, STI 1011. Any memory op with in_valid = 0 is ignored.
- IDLE, non-memory op or bubble:
  - No request; stall_pipeline = 0.
  - regfilemux_out = alu_out; load_regfile_out = load_regfile_in & in_valid.
- IDLE, memory op: request is driven combinationally in the same cycle; stall_pipeline = 1 until the completing mem_resp.
  - LDR/STR: mem_address = {alu_out[15:1],0}; mem_byte_enable = 11.
  - LDB/STB: mem_address = alu_out.
  - LDI/STI: word read at {alu_out[15:1],0}. On mem_resp, ptr <= mem_rdata and state → INDIRECT. stall_pipeline stays 1 on that cycle.
  - Other ops: on mem_resp, stall_pipeline = 0 that cycle; stay IDLE.
- INDIRECT:
  - LDI: mem_read at {ptr[15:1],0}.
  - STI: mem_write at {ptr[15:1],0}, byte_enable 11.
  - On mem_resp: state → IDLE, stall_pipeline = 0 that cycle.
  - mem_read/mem_write may go from the first access straight into the second with no idle cycle.
- Load results are valid on the completing mem_resp cycle:
  - LDR/LDI: regfilemux_out = mem_rdata.
  - LDB: zero-extended mem_rdata[7:0] if alu_out[0] = 0, else mem_rdata[15:8].
  - load_regfile_out = load_regfile_in on that cycle only; 0 on all other stalled cycles.
- Store data:
  - STB: mem_wdata = {store_data[7:0], store_data[7:0]}; byte_enable = 01 if alu_out[0] = 0, else 10.
  - Stores: load_regfile_out = 0.
- dest_out = dest_in always (unregistered).
- stall_cycles increments each cycle stall_pipeline = 1 and saturates at all-ones.
- Reset asserted mid-access: FSM → IDLE and requests drop immediately. A mem_resp arriving after reset release in IDLE with no memory op is ignored.
- mem_rdata is ignored on cycles without mem_resp.

Test Plan:
- ADD, alu_out = 0x1234, load_regfile_in = 1, dest 3 → same cycle: regfilemux_out = 0x1234, load_regfile_out = 1, stall 0, no request.
- LDR addr 0x0061, mem_resp after 3 cycles with 0xBEEF → mem_address 0x0060; stall high 3 cycles, low on resp; regfilemux_out 0xBEEF, load_regfile_out 1 on resp cycle only; stall_cycles = 3.
- LDB addr 0x0101, rdata 0xA55A → byte_enable unused; regfilemux_out 0x00A5. STB addr 0x0100, store_data 0x12CD → wdata 0xCDCD, byte_enable 01, load_regfile_out 0.
- LDI addr 0x0200: first resp rdata 0x3001 → mem_address 0x3000 next cycle, stall still 1. Second resp 0x7777 → regfilemux_out 0x7777, stall 0.
- STI addr 0x0400 → pointer 0x5000, then mem_write at 0x5000 with store_data, byte_enable 11. Bubble (in_valid = 0) with opcode LDR → no request, stall 0.
- rst_n pulsed low while in INDIRECT → mem_read 0, stall 0 immediately. After release, a stray mem_resp with ADD present changes nothing; the FSM stays IDLE.
